// File: rtl/game_pkg.sv
// Shared constants for the Memory-Game button front end: channel indices,
// debounce lengths for board and bench builds, and the counter-width helper.
package game_pkg;

    localparam int unsigned N_BUTTONS_DEFAULT = 4;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    // 5 ms at 100 MHz for the board; a short window keeps benches fast.
    localparam int unsigned DEBOUNCE_CYCLES_HW  = 500000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    // Width that holds 0 .. cycles-1; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchroniser, stability counter, accepted
// level, and registered press/release strobes.
module debounce_cell
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_strobe
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;

        // Any sample agreeing with the accepted level restarts the window,
        // so bounces and short glitches never reach the accept branch.
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        level_d   = stable_q;
        press_d   = stable_q & ~level_q;
        release_d = ~stable_q & level_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level          = level_q;
    assign press          = press_q;
    assign release_strobe = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw push-buttons into clean levels plus one-cycle
// press/release strobes; any_press flags a press on any channel.
module button_debouncer
    import game_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = N_BUTTONS_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic                 any_press
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clock         (clock),
            .reset         (reset),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press         (btn_press[i]),
            .release_strobe(btn_release[i])
        );
    end

    assign any_press = |btn_press;

endmodule
